// File: rtl/kernel_buffer_pkg.sv
// kernel_buffer_pkg: loader state encoding and ioInputs field offsets shared by
// kernel_buffer_loader and its testbench.
package kernel_buffer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LAST} state_e;
  function automatic int data_lsb();
    return 0;
  endfunction
  function automatic int bank_lsb(input int w);
    return w;
  endfunction
  function automatic int write_bit(input int w, input int depth);
    return w + depth;
  endfunction
  function automatic int sel_bit(input int w, input int depth);
    return w + depth + 1;
  endfunction
endpackage

// File: rtl/kernel_beat_counter.sv
// kernel_beat_counter: bank-first write position; bank wraps into an address
// increment, address wraps modulo 2^A, both reload on load_i.
module kernel_beat_counter #(
  parameter int depth = 2,
  parameter int A = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [A-1:0]     base_i,
  input  logic             adv_i,
  output logic [depth-1:0] bank_o,
  output logic [A-1:0]     addr_o
);
  logic [depth-1:0] bank_q, bank_d;
  logic [A-1:0] addr_q, addr_d;
  always_comb begin
    bank_d = load_i ? '0 : adv_i ? bank_q + 1'b1 : bank_q;
    addr_d = load_i ? base_i : (adv_i && &bank_q) ? addr_q + 1'b1 : addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end
  assign bank_o = bank_q;
  assign addr_o = addr_q;
endmodule

// File: rtl/kernel_buffer_loader.sv
// kernel_buffer_loader: streams weight words into the kernel buffer IO port, bank-first.
// Optional running checksum enabled by defining KERNEL_LOADER_CHECKSUM_EN.
module kernel_buffer_loader
  import kernel_buffer_pkg::*;
#(
  parameter int depth = 2,
  parameter int A = 7,
  parameter int W = 16
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 start,
  input  logic [A-1:0]         baseAddress,
  input  logic [A+depth-1:0]   wordCount,
  input  logic [W-1:0]         inData,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [W+depth+1:0]   ioInputs,
  output logic [A-1:0]         address,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         checksum
);
  localparam int DL = data_lsb();
  localparam int BL = bank_lsb(W);
  localparam int WB = write_bit(W, depth);
  localparam int SB = sel_bit(W, depth);
  state_e state_q, state_d;
  logic [A+depth-1:0] rem_q, rem_d;
  logic [W+depth+1:0] io_q, io_d;
  logic [A-1:0] addr_q, addr_d, cnt_addr;
  logic [depth-1:0] cnt_bank;
  logic done_q, done_d, accept, beat;
  assign accept = state_q == S_IDLE && start;
  assign beat = state_q == S_LOAD && inValid;
  kernel_beat_counter #(.depth(depth), .A(A)) u_cnt (
    .clk   (CLK),
    .rst_n (RESETn),
    .load_i(accept),
    .base_i(baseAddress),
    .adv_i (beat),
    .bank_o(cnt_bank),
    .addr_o(cnt_addr)
  );
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == S_IDLE ? (start ? (wordCount == '0 ? S_LAST : S_LOAD) : S_IDLE)
            : state_q == S_LOAD ? ((beat && rem_q == (A+depth)'(1)) ? S_LAST : S_LOAD)
            : S_IDLE;
  end
  always_comb begin
    inReady  = state_q == S_LOAD;
    busy     = state_q != S_IDLE;
    ioInputs = io_q;
    address  = addr_q;
    done     = done_q;
  end
  // select follows LOAD, so leaving LAST clears select and write together
  always_comb begin
    rem_d = accept ? wordCount : beat ? rem_q - 1'b1 : rem_q;
    io_d = io_q;
    io_d[SB] = state_q == S_LOAD;
    io_d[WB] = beat;
    if (beat) begin
      io_d[BL +: depth] = cnt_bank;
      io_d[DL +: W] = inData;
    end
    addr_d = beat ? cnt_addr : addr_q;
    done_d = state_q == S_LAST;
  end
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rem_q  <= '0;
      io_q   <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      io_q   <= io_d;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end
`ifdef KERNEL_LOADER_CHECKSUM_EN
  logic [W-1:0] sum_q, sum_d;
  always_comb sum_d = accept ? '0 : beat ? sum_q + inData : sum_q;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif
endmodule
